seven_seg_scan_ctrl: RTL

Refresh controller for the eight-digit seven-segment display. It time-multiplexes the digits by producing the 3-bit digit select that drives the 8:1 nibble mux feeding the segment decoder. It also produces the matching active-low anode enables, so that exactly one digit is lit per refresh slot. It is the stage directly upstream of the display nibble mux: it generates that mux's select and consumes nothing from it.

---
 rtl/display_pkg.sv | 26 ++
 rtl/refresh_tick_gen.sv | 37 +++
 rtl/seven_seg_scan_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the seven-segment display datapath: digit count,
// select width, all-anodes-off constant, scan FSM states and anode decode.
package display_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned SEL_W      = 3;

  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 8'hFF;

  typedef enum logic {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } scan_state_t;

  // Active-low one-cold enable for digit sel, gated by the per-digit mask.
  function automatic logic [NUM_DIGITS-1:0] anode_decode(
    input logic [SEL_W-1:0]      sel,
    input logic [NUM_DIGITS-1:0] mask
  );
    logic [NUM_DIGITS-1:0] onehot;
    onehot      = '0;
    onehot[sel] = 1'b1;
    return ~(onehot & mask);
  endfunction

endpackage

// File: rtl/refresh_tick_gen.sv
// Free-running modulo-DIV divider; tc_o is high while the count sits at DIV-1.
// Reusable timebase for any slot-based display logic.
module refresh_tick_gen #(
  parameter int unsigned DIV = 100000
) (
  input  logic clk_i,
  input  logic reset_i,
  output logic tc_o
);

  localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             tc;

  if (DIV < 2) begin : g_bad_div
    $error("refresh_tick_gen: DIV must be at least 2");
  end

  always_comb begin
    tc    = (cnt_q == LAST);
    cnt_d = tc ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = tc;

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Eight-digit seven-segment refresh controller: digit select, active-low anodes
// and slot tick, all registered. Define SCAN_GHOST_BLANK_EN for per-slot anode blanking.
module seven_seg_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_DIGITS-1:0] en_mask,
  output logic [SEL_W-1:0]      seg_sel,
  output logic [NUM_DIGITS-1:0] anode,
  output logic                  tick
);

  if ((BLANK_CYCLES < 1) || (BLANK_CYCLES >= REFRESH_DIV)) begin : g_bad_blank
    $error("seven_seg_scan_ctrl: need 1 <= BLANK_CYCLES < REFRESH_DIV");
  end

  logic                  tc;
  logic [SEL_W-1:0]      seg_sel_q;
  logic [SEL_W-1:0]      seg_sel_d;
  logic [NUM_DIGITS-1:0] anode_q;
  logic [NUM_DIGITS-1:0] anode_d;
  logic                  tick_q;
  logic                  show_d;

  refresh_tick_gen #(
    .DIV (REFRESH_DIV)
  ) u_refresh_tick_gen (
    .clk_i   (clk),
    .reset_i (reset),
    .tc_o    (tc)
  );

  always_comb begin
    seg_sel_d = tc ? seg_sel_q + 1'b1 : seg_sel_q;
  end

`ifdef SCAN_GHOST_BLANK_EN
  localparam int unsigned BLK_W = $clog2(BLANK_CYCLES + 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLANK_CYCLES - 1);

  scan_state_t      state_q;
  scan_state_t      state_d;
  logic [BLK_W-1:0] blank_cnt_q;
  logic [BLK_W-1:0] blank_cnt_d;

  always_comb begin
    state_d     = state_q;
    blank_cnt_d = blank_cnt_q;
    case (state_q)
      SHOW: begin
        if (tc) begin
          state_d     = BLANK;
          blank_cnt_d = '0;
        end
      end
      BLANK: begin
        // A slot boundary inside BLANK restarts the blank window for the new digit.
        if (tc) begin
          blank_cnt_d = '0;
        end else if (blank_cnt_q == BLK_LAST) begin
          state_d = SHOW;
        end else begin
          blank_cnt_d = blank_cnt_q + 1'b1;
        end
      end
      default: state_d = SHOW;
    endcase
    show_d = (state_d == SHOW);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SHOW;
      blank_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      blank_cnt_q <= blank_cnt_d;
    end
  end
`else
  always_comb begin
    show_d = 1'b1;
  end
`endif

  // Anodes come from next-state select/state so select and anode switch together.
  always_comb begin
    anode_d = show_d ? anode_decode(seg_sel_d, en_mask) : ANODE_OFF;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_sel_q <= '0;
      anode_q   <= ANODE_OFF;
      tick_q    <= 1'b0;
    end else begin
      seg_sel_q <= seg_sel_d;
      anode_q   <= anode_d;
      tick_q    <= tc;
    end
  end

  assign seg_sel = seg_sel_q;
  assign anode   = anode_q;
  assign tick    = tick_q;

endmodule
